// File: rtl/ctr_pkg.sv
// Shared types and helpers for the parametrised step counter.
// Purely declarative: no logic, no latency.
// No flow control; consumers decide how these types are used.
package ctr_pkg;

    // 2'b11 has no name on purpose: it decodes as wrap in the datapath.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam int MAX_WIDTH = 32;

    // Carried at MAX_WIDTH+1 bits so a 32-bit counter with MODULUS=2**32 fits.
    function automatic logic [MAX_WIDTH:0] clamp_load(
        input logic [MAX_WIDTH:0] value,
        input logic [MAX_WIDTH:0] modulus
    );
        return (value >= modulus) ? (modulus - 33'd1) : value;
    endfunction

endpackage

// File: rtl/ctr_next_calc.sv
// Next-count calculator: one step up or down with wrap/clip at the boundary.
// Latency: purely combinational.
// No flow control; the caller decides whether to take the result.
// Ports: count/up_dn/mode in; next_val, crossed (boundary hit),
//        clip_changed (clipping moved the value) out.
module ctr_next_calc
    import ctr_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256,
    parameter longint STEP    = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_val,
    output logic             crossed,
    output logic             clip_changed
);

    // All arithmetic is one bit wider than the count so nothing overflows.
    localparam logic [WIDTH:0] MOD_W  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0] STEP_W = STEP[WIDTH:0];
    localparam logic [WIDTH:0] MAX_W  = MOD_W - (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] next_full;
    logic           sat_like;
    logic           unused_next_hi;

    assign cnt_x    = {1'b0, count};
    assign sum      = cnt_x + STEP_W;
    assign sat_like = (mode == MODE_SAT) || (mode == MODE_ONESHOT);

    always_comb begin
        next_full    = cnt_x;
        crossed      = 1'b0;
        clip_changed = 1'b0;
        if (up_dn) begin
            crossed = (sum >= MOD_W);
            if (!crossed) begin
                next_full = sum;
            end else if (sat_like) begin
                next_full    = MAX_W;
                clip_changed = (cnt_x != MAX_W);
            end else begin
                next_full = sum - MOD_W;
            end
        end else begin
            crossed = (cnt_x < STEP_W);
            if (!crossed) begin
                next_full = cnt_x - STEP_W;
            end else if (sat_like) begin
                next_full    = '0;
                clip_changed = (cnt_x != '0);
            end else begin
                // count < STEP here, so the sum stays below MODULUS.
                next_full = cnt_x + (MOD_W - STEP_W);
            end
        end
    end

    // The result is always < MODULUS <= 2**WIDTH, so the top bit is zero.
    assign next_val       = next_full[WIDTH-1:0];
    assign unused_next_hi = next_full[WIDTH];

endmodule

// File: rtl/mod_step_counter.sv
// Modulo step counter with wrap/saturate/one-shot modes, load, clear and enable.
// Latency: count/wrap/done update one clock after inputs are sampled; tc is combinational.
// No backpressure: every enabled cycle advances unless the one-shot has finished.
// Ports: clk, rst (async, active-high), en, up_dn, mode, clear, load, load_val in;
//        count, tc, wrap, done out.
module mod_step_counter
    import ctr_pkg::*;
#(
    parameter int     WIDTH   = 8,
    parameter longint MODULUS = 256,
    parameter longint STEP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH) || STEP < 1 || STEP >= MODULUS) begin : g_param_check
        $fatal(1, "mod_step_counter: illegal WIDTH/MODULUS/STEP combination");
    end

    localparam logic [WIDTH:0]     MOD_W   = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]     MAX_W   = MOD_W - (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0]   MAX_CNT = MAX_W[WIDTH-1:0];
    localparam logic [MAX_WIDTH:0] MOD_33  = MODULUS[MAX_WIDTH:0];

    state_e             state;
    logic [WIDTH-1:0]   next_val;
    logic               crossed;
    logic               clip_changed;
    logic [MAX_WIDTH:0] load_full;
    logic [MAX_WIDTH:0] load_clamped;
    logic               unused_load_hi;

    ctr_next_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP    (STEP)
    ) u_next (
        .count        (count),
        .up_dn        (up_dn),
        .mode         (mode),
        .next_val     (next_val),
        .crossed      (crossed),
        .clip_changed (clip_changed)
    );

    assign load_full      = {{(MAX_WIDTH + 1 - WIDTH){1'b0}}, load_val};
    assign load_clamped   = clamp_load(load_full, MOD_33);
    assign unused_load_hi = ^load_clamped[MAX_WIDTH:WIDTH];

    assign tc   = up_dn ? (count == MAX_CNT) : (count == '0);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
            state <= ST_RUN;
        end else if (clear) begin
            count <= '0;
            wrap  <= 1'b0;
            state <= ST_RUN;
        end else if (load) begin
            count <= load_clamped[WIDTH-1:0];
            wrap  <= 1'b0;
            state <= ST_RUN;
        end else begin
            wrap <= 1'b0;
            // A finished one-shot freezes until cleared, loaded or moved out of
            // one-shot mode; leaving the mode lets this cycle's enable count.
            if (!(state == ST_DONE && mode == MODE_ONESHOT)) begin
                state <= ST_RUN;
                if (en) begin
                    count <= next_val;
                    if (crossed) begin
                        // Saturate only flags a clip that actually moved the count.
                        wrap <= (mode == MODE_SAT) ? clip_changed : 1'b1;
                        if (mode == MODE_ONESHOT) begin
                            state <= ST_DONE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_step_counter.sv
module tb_mod_step_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic [1:0] mode;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       wrap;
    logic       done;
    logic [7:0] count2;
    logic       tc2;
    logic       wrap2;
    logic       done2;

    always #5 clk = ~clk;

    mod_step_counter #(.WIDTH(8), .MODULUS(10), .STEP(3)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
        .clear(clear), .load(load), .load_val(load_val),
        .count(count), .tc(tc), .wrap(wrap), .done(done)
    );

    mod_step_counter #(.WIDTH(8), .MODULUS(256), .STEP(1)) dut_legacy (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
        .clear(clear), .load(load), .load_val(load_val),
        .count(count2), .tc(tc2), .wrap(wrap2), .done(done2)
    );

    typedef struct {
        string      name;
        logic       clear;
        logic       load;
        logic [7:0] load_val;
        logic       en;
        logic       up_dn;
        logic [1:0] mode;
        logic [7:0] e_count;
        logic       e_wrap;
        logic       e_done;
        logic       e_tc;
    } vec_t;

    typedef struct {
        string      name;
        logic       chk1;
        logic [7:0] count;
        logic       wrap;
        logic       done;
        logic       tc;
        logic       chk2;
        logic [7:0] count2;
        logic       wrap2;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.chk1) begin
                check({e.name, " count"}, 32'(count), 32'(e.count));
                check({e.name, " wrap"},  32'(wrap),  32'(e.wrap));
                check({e.name, " done"},  32'(done),  32'(e.done));
                check({e.name, " tc"},    32'(tc),    32'(e.tc));
            end
            if (e.chk2) begin
                check({e.name, " legacy count"}, 32'(count2), 32'(e.count2));
                check({e.name, " legacy wrap"},  32'(wrap2),  32'(e.wrap2));
            end
        end
    endtask

    // Compare the previous expectation, then drive new inputs and queue theirs.
    task automatic apply(input vec_t v, input logic chk1, input logic chk2,
                         input logic [7:0] c2, input logic w2);
        exp_t e;
        @(negedge clk);
        compare_head();
        clear    = v.clear;
        load     = v.load;
        load_val = v.load_val;
        en       = v.en;
        up_dn    = v.up_dn;
        mode     = v.mode;
        e.name   = v.name;
        e.chk1   = chk1;
        e.count  = v.e_count;
        e.wrap   = v.e_wrap;
        e.done   = v.e_done;
        e.tc     = v.e_tc;
        e.chk2   = chk2;
        e.count2 = c2;
        e.wrap2  = w2;
        sbq.push_back(e);
    endtask

    function automatic vec_t mk(input string n, input logic cl, input logic ld,
                                input logic [7:0] lv, input logic e, input logic ud,
                                input logic [1:0] m, input logic [7:0] c,
                                input logic w, input logic d, input logic t);
        vec_t v;
        v.name = n; v.clear = cl; v.load = ld; v.load_val = lv; v.en = e;
        v.up_dn = ud; v.mode = m; v.e_count = c; v.e_wrap = w; v.e_done = d; v.e_tc = t;
        return v;
    endfunction

    initial begin
        logic [7:0] m2;

        rst = 1'b1; en = 1'b0; up_dn = 1'b0; mode = 2'b00;
        clear = 1'b0; load = 1'b0; load_val = 8'd0;
        #12;
        check("reset count", 32'(count), 0);
        check("reset wrap",  32'(wrap),  0);
        check("reset done",  32'(done),  0);
        check("reset tc_dn", 32'(tc),    1);
        @(negedge clk);
        rst = 1'b0;

        //           name        clr ld  lv  en ud mode   cnt w d tc
        // wrap up from reset
        tbl.push_back(mk("wu1",   0, 0,  0, 1, 1, 2'b00, 3, 0, 0, 0));
        tbl.push_back(mk("wu2",   0, 0,  0, 1, 1, 2'b00, 6, 0, 0, 0));
        tbl.push_back(mk("wu3",   0, 0,  0, 1, 1, 2'b00, 9, 0, 0, 1));
        tbl.push_back(mk("wu4",   0, 0,  0, 1, 1, 2'b00, 2, 1, 0, 0));
        tbl.push_back(mk("wu5",   0, 0,  0, 1, 1, 2'b00, 5, 0, 0, 0));
        // wrap down
        tbl.push_back(mk("wdld",  0, 1,  1, 0, 0, 2'b00, 1, 0, 0, 0));
        tbl.push_back(mk("wd1",   0, 0,  0, 1, 0, 2'b00, 8, 1, 0, 0));
        tbl.push_back(mk("wd2",   0, 0,  0, 1, 0, 2'b00, 5, 0, 0, 0));
        tbl.push_back(mk("wd3",   0, 0,  0, 1, 0, 2'b00, 2, 0, 0, 0));
        tbl.push_back(mk("wd4",   0, 0,  0, 1, 0, 2'b00, 9, 1, 0, 0));
        // reserved mode behaves as wrap
        tbl.push_back(mk("rsv",   0, 0,  0, 1, 0, 2'b11, 6, 0, 0, 0));
        // saturate
        tbl.push_back(mk("sld",   0, 1,  8, 1, 1, 2'b01, 8, 0, 0, 0));
        tbl.push_back(mk("su1",   0, 0,  0, 1, 1, 2'b01, 9, 1, 0, 1));
        tbl.push_back(mk("su2",   0, 0,  0, 1, 1, 2'b01, 9, 0, 0, 1));
        tbl.push_back(mk("su3",   0, 0,  0, 1, 1, 2'b01, 9, 0, 0, 1));
        tbl.push_back(mk("sd1",   0, 0,  0, 1, 0, 2'b01, 6, 0, 0, 0));
        tbl.push_back(mk("sd2",   0, 0,  0, 1, 0, 2'b01, 3, 0, 0, 0));
        tbl.push_back(mk("sd3",   0, 0,  0, 1, 0, 2'b01, 0, 0, 0, 1));
        tbl.push_back(mk("sd4",   0, 0,  0, 1, 0, 2'b01, 0, 0, 0, 1));
        tbl.push_back(mk("hold",  0, 0,  0, 0, 0, 2'b01, 0, 0, 0, 1));
        // one-shot
        tbl.push_back(mk("oclr",  1, 0,  0, 1, 1, 2'b10, 0, 0, 0, 0));
        tbl.push_back(mk("o1",    0, 0,  0, 1, 1, 2'b10, 3, 0, 0, 0));
        tbl.push_back(mk("o2",    0, 0,  0, 1, 1, 2'b10, 6, 0, 0, 0));
        tbl.push_back(mk("o3",    0, 0,  0, 1, 1, 2'b10, 9, 0, 0, 1));
        tbl.push_back(mk("odone", 0, 0,  0, 1, 1, 2'b10, 9, 1, 1, 1));
        tbl.push_back(mk("ohold", 0, 0,  0, 1, 1, 2'b10, 9, 0, 1, 1));
        tbl.push_back(mk("oexit", 0, 0,  0, 1, 1, 2'b00, 2, 1, 0, 0));
        tbl.push_back(mk("clrld", 1, 1, 15, 1, 1, 2'b10, 0, 0, 0, 0));
        tbl.push_back(mk("o4",    0, 0,  0, 1, 1, 2'b10, 3, 0, 0, 0));
        tbl.push_back(mk("ld15",  0, 1, 15, 0, 1, 2'b10, 9, 0, 0, 1));
        // priority: clear over load over enable
        tbl.push_back(mk("prio",  1, 1,  5, 1, 1, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk("ldpri", 0, 1,  5, 1, 1, 2'b00, 5, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], 1'b1, 1'b0, 8'd0, 1'b0);

        // Reach DONE, then hit an asynchronous reset between clock edges.
        apply(mk("r0", 1, 0, 0, 1, 1, 2'b10, 0, 0, 0, 0), 1'b1, 1'b0, 8'd0, 1'b0);
        apply(mk("r1", 0, 0, 0, 1, 1, 2'b10, 3, 0, 0, 0), 1'b1, 1'b0, 8'd0, 1'b0);
        apply(mk("r2", 0, 0, 0, 1, 1, 2'b10, 6, 0, 0, 0), 1'b1, 1'b0, 8'd0, 1'b0);
        apply(mk("r3", 0, 0, 0, 1, 1, 2'b10, 9, 0, 0, 1), 1'b1, 1'b0, 8'd0, 1'b0);
        apply(mk("r4", 0, 0, 0, 1, 1, 2'b10, 9, 1, 1, 1), 1'b1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        compare_head();
        #2 rst = 1'b1;
        #1;
        check("async rst count", 32'(count), 0);
        check("async rst wrap",  32'(wrap),  0);
        check("async rst done",  32'(done),  0);
        @(negedge clk);
        check("rst held count", 32'(count), 0);
        en = 1'b0;
        mode = 2'b00;
        rst = 1'b0;
        apply(mk("resume", 0, 0, 0, 1, 1, 2'b00, 3, 0, 0, 0), 1'b1, 1'b0, 8'd0, 1'b0);

        // Legacy configuration on the second instance: 0..255 then back to 0.
        apply(mk("lclr", 1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0), 1'b0, 1'b1, 8'd0, 1'b0);
        m2 = 8'd0;
        for (int i = 0; i < 260; i++) begin
            m2 = (m2 == 8'd255) ? 8'd0 : m2 + 8'd1;
            apply(mk("leg", 0, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0), 1'b0, 1'b1, m2, (m2 == 8'd0));
        end
        @(negedge clk);
        compare_head();
        check("scoreboard drained", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
